poly_fifo_drain: RTL and testbench
==================================

# poly_fifo_drain

Sink-side reader for the ping-pong polynomial FIFO: the counterpart of the writer that fills a buffer through the source port. When a buffer becomes available it latches the header (rlwe_id, poly_id, opcode), reads the polynomial out as line pairs over the FIFO's two read ports, and emits them on a valid/ready stream. After the last pair is accepted it pulses `rd_finish` to release the buffer. It sits between the FIFO sink port and the downstream consumer (AXI write-back packer or next compute stage).

## Interface
Parameters:
- `RD_LAT`, 1: FIFO read latency in cycles from address to `dA`/`dB`; legal values are 1 and 2.
- `SKID_DEPTH`, `RD_LAT`+1: output buffer entries; must be ≥ `RD_LAT`+1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `length`  in  12  polynomial length (config `length`), sampled on buffer start.
- `addrA`  out  `ADDR_WIDTH`  line address, lower half.
- `addrB`  out  `ADDR_WIDTH`  line address, upper half (`addrA` + lines/2).
- `dA`, `dB`  in  `BIT_WIDTH*LINE_SIZE`  read data, valid `RD_LAT` cycles after the address.
- `empty`  in  1  high means no filled buffer is available.
- `rlwe_id`, `poly_id`, `opcode`  in  `RLWE_ID_WIDTH`/`POLY_ID_WIDTH`/`OPCODE_WIDTH`  header of the current buffer.
- `rd_finish`  out  1  one-cycle pulse that releases the buffer.
- `m_valid`  out  1, `m_ready`  in  1  output handshake.
- `m_data`  out  `2*BIT_WIDTH*LINE_SIZE`  {dB, dA}.
- `m_last`  out  1  marks the final pair of the polynomial.
- `m_rlwe_id`, `m_poly_id`, `m_opcode`  out  header, constant for the whole polynomial.

## Operation
- `lines` = `length` >> log2(`LINE_SIZE`); `pairs` = `lines`/2. `LINE_SIZE` is a power of 2 and `pairs` ≥ 1.
- FSM states:
  - IDLE: on `empty`=0, latch the header and `pairs`, clear counters, go to READ.
  - READ: issue pair i (`addrA`=i, `addrB`=i+`pairs`) in any cycle where (in-flight + buffered) < `SKID_DEPTH`. After issuing i=`pairs`-1, go to DRAIN.
  - DRAIN: wait until the final beat is accepted (`m_valid`&`m_ready`&`m_last`), then go to FIN.
  - FIN: `rd_finish`=1 for exactly one cycle, then go to GUARD.
  - GUARD: one cycle so the FIFO can update `empty`, then go to IDLE.
- Read data enters the skid FIFO `RD_LAT` cycles after issue, tagged with a last flag when i=`pairs`-1.
- Addresses hold their last value when no read is issued. The FIFO has no read enable, so duplicate reads are harmless and untracked.
- `m_data` and `m_last` come from the skid head. They remain stable while `m_valid`=1 and `m_ready`=0.
- `length`, header and `empty` are ignored outside IDLE.
- Reset mid-polynomial: everything is cleared, the partial polynomial is abandoned, and `rd_finish` is not pulsed. The FIFO is reset by the same `rst`.

## Timing
- Reset values: `addrA`=`addrB`=0, `rd_finish`=0, `m_valid`=0, `m_last`=0, `m_data`=0, header outputs 0, FSM=IDLE.
- `empty` falls at cycle t → READ at t+1 with pair 0 issued → `m_valid` at t+1+`RD_LAT`.
- Throughput: with `m_ready` held high, one pair per cycle and no bubbles.
- `m_ready` low: issue stops once in-flight + buffered = `SKID_DEPTH`, so no beat is ever dropped.
- Final acceptance at cycle u → `rd_finish` at u+1 → IDLE at u+3. The next buffer's first beat appears at u+4+`RD_LAT` at earliest.

## Configuration
- `FHE_DRAIN_STATS_EN` defined:
  - Adds `stat_polys` (out 32): number of `rd_finish` pulses.
  - Adds `stat_stalls` (out 32): cycles with `m_valid`&!`m_ready`.
  - Both counters clear on `rst` and wrap at 2^32.
- `FHE_DRAIN_STATS_EN` undefined: neither the ports nor the logic exist.

## Test plan
Bench uses `LINE_SIZE`=8.
- Basic drain: `length`=1024, `m_ready`=1, `empty` falls at t → 64 beats on consecutive cycles starting t+2 (`RD_LAT`=1). Beat k carries {line k+64, line k}; `m_last` only on beat 63; `rd_finish` one cycle after beat 63.
- Backpressure: `m_ready` toggles 1,0,0,1 repeating → all 64 pairs in order with no loss or duplication; `m_data` stable during stalls; in-flight + buffered never exceeds 2.
- Back-to-back buffers: `empty` stays 0 and the header changes from poly_id 0 to poly_id 1 → second polynomial starts 4+`RD_LAT` cycles after the first `m_last` acceptance, with `m_poly_id`=1.
- Minimum length: `length`=16 (pairs=1) → a single beat with `m_last`=1, then a single `rd_finish` pulse.
- Reset mid-operation: assert `rst` after beat 10 → next cycle `m_valid`=0, `rd_finish` never asserted, FSM in IDLE. A fresh buffer then drains from pair 0.
- `RD_LAT`=2, `m_ready` low for 20 cycles → exactly 3 beats buffered, issue stalls, and the stream resumes correctly when `m_ready` returns high.

Source files
------------

// File: rtl/poly_fifo_drain_if.sv
// poly_fifo_drain_if: FIFO sink port and output stream bundle for poly_fifo_drain
// master: drain side (drives addresses, rd_finish, stream); slave: FIFO + consumer side
// Signals: length, addrA/addrB, dA/dB, empty, rlwe_id/poly_id/opcode, rd_finish,
//          m_valid/m_ready, m_data, m_last, m_rlwe_id/m_poly_id/m_opcode
interface poly_fifo_drain_if #(
    parameter int ADDR_WIDTH    = 8,
    parameter int BIT_WIDTH     = 8,
    parameter int LINE_SIZE     = 8,
    parameter int RLWE_ID_WIDTH = 4,
    parameter int POLY_ID_WIDTH = 4,
    parameter int OPCODE_WIDTH  = 4
);
    logic [11:0]                        length;
    logic [ADDR_WIDTH-1:0]              addrA, addrB;
    logic [BIT_WIDTH*LINE_SIZE-1:0]     dA, dB;
    logic                               empty;
    logic [RLWE_ID_WIDTH-1:0]           rlwe_id, m_rlwe_id;
    logic [POLY_ID_WIDTH-1:0]           poly_id, m_poly_id;
    logic [OPCODE_WIDTH-1:0]            opcode, m_opcode;
    logic                               rd_finish;
    logic                               m_valid, m_ready, m_last;
    logic [2*BIT_WIDTH*LINE_SIZE-1:0]   m_data;
    modport master (
        input  length, dA, dB, empty, rlwe_id, poly_id, opcode, m_ready,
        output addrA, addrB, rd_finish, m_valid, m_data, m_last, m_rlwe_id, m_poly_id, m_opcode
    );
    modport slave (
        output length, dA, dB, empty, rlwe_id, poly_id, opcode, m_ready,
        input  addrA, addrB, rd_finish, m_valid, m_data, m_last, m_rlwe_id, m_poly_id, m_opcode
    );
endinterface

// File: rtl/poly_fifo_drain.sv
// poly_fifo_drain: reads a ping-pong FIFO buffer as line pairs and streams them out
// Ports: clk, rst (sync, active-high), bus (poly_fifo_drain_if.master: FIFO sink port + output stream)
// Optional FHE_DRAIN_STATS_EN adds stat_polys (rd_finish count) and stat_stalls (valid & !ready cycles)
module poly_fifo_drain #(
    parameter int ADDR_WIDTH    = 8,
    parameter int BIT_WIDTH     = 8,
    parameter int LINE_SIZE     = 8,
    parameter int RLWE_ID_WIDTH = 4,
    parameter int POLY_ID_WIDTH = 4,
    parameter int OPCODE_WIDTH  = 4,
    parameter int RD_LAT        = 1,
    parameter int SKID_DEPTH    = RD_LAT + 1
) (
    input  logic clk,
    input  logic rst,
    poly_fifo_drain_if.master bus
`ifdef FHE_DRAIN_STATS_EN
    ,
    output logic [31:0] stat_polys,
    output logic [31:0] stat_stalls
`endif
);
    localparam int DW = 2 * BIT_WIDTH * LINE_SIZE;
    localparam int SH = $clog2(LINE_SIZE) + 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    typedef enum logic [2:0] {IDLE, READ, DRAIN, FIN, GUARD} state_t;
    state_t state_q, state_d;
    logic [11:0] pairs_q, pairs_d, idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [RLWE_ID_WIDTH-1:0] rlwe_q, rlwe_d;
    logic [POLY_ID_WIDTH-1:0] poly_q, poly_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [CW-1:0] occ_q, occ_d, cnt_q, cnt_d;
    logic [RD_LAT-1:0] pv_q, pv_d, pl_q, pl_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [SKID_DEPTH-1:0] lst_q, lst_d;
    logic [DW-1:0] mem_q [SKID_DEPTH];
    logic [DW-1:0] mem_d [SKID_DEPTH];
    logic issue, last_issue, in_v, in_l, pop, push, pop_mem, has;
    // occ counts reads in flight plus beats buffered, so the skid can never overflow
    assign issue = (state_q == READ) && (occ_q < CW'(SKID_DEPTH));
    assign last_issue = issue && (idx_q == pairs_q - 12'd1);
    assign in_v = pv_q[RD_LAT-1];
    assign in_l = pl_q[RD_LAT-1];
    assign has = cnt_q != '0;
    // fall-through skid: an empty skid presents returning read data directly
    assign bus.m_valid = has || in_v;
    assign bus.m_data = has ? mem_q[rd_q] : (in_v ? {bus.dB, bus.dA} : '0);
    assign bus.m_last = has ? lst_q[rd_q] : in_v & in_l;
    assign pop = bus.m_valid & bus.m_ready;
    assign pop_mem = pop & has;
    assign push = in_v & ~(pop & ~has);
    assign bus.addrA = addr_a_q;
    assign bus.addrB = addr_b_q;
    assign bus.rd_finish = state_q == FIN;
    assign bus.m_rlwe_id = rlwe_q;
    assign bus.m_poly_id = poly_q;
    assign bus.m_opcode = op_q;
    always_comb begin
        state_d = state_q;
        pairs_d = pairs_q;
        idx_d = idx_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        rlwe_d = rlwe_q;
        poly_d = poly_q;
        op_d = op_q;
        case (state_q)
            IDLE: if (!bus.empty) begin
                state_d = READ;
                pairs_d = bus.length >> SH;
                idx_d = '0;
                addr_a_d = '0;
                addr_b_d = ADDR_WIDTH'(bus.length >> SH);
                rlwe_d = bus.rlwe_id;
                poly_d = bus.poly_id;
                op_d = bus.opcode;
            end
            READ: if (issue) begin
                state_d = last_issue ? DRAIN : READ;
                idx_d = idx_q + 12'd1;
                addr_a_d = last_issue ? addr_a_q : addr_a_q + ADDR_WIDTH'(1);
                addr_b_d = last_issue ? addr_b_q : addr_b_q + ADDR_WIDTH'(1);
            end
            DRAIN: state_d = (pop && bus.m_last) ? FIN : DRAIN;
            FIN: state_d = GUARD;
            GUARD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        pv_d = RD_LAT'({pv_q, issue});
        pl_d = RD_LAT'({pl_q, last_issue});
        occ_d = occ_q + CW'(issue) - CW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop_mem);
        wr_d = push ? ((wr_q == PW'(SKID_DEPTH - 1)) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d = pop_mem ? ((rd_q == PW'(SKID_DEPTH - 1)) ? '0 : rd_q + PW'(1)) : rd_q;
        lst_d = lst_q;
        mem_d = mem_q;
        if (push) begin
            lst_d[wr_q] = in_l;
            mem_d[wr_q] = {bus.dB, bus.dA};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pairs_q <= '0;
            idx_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            rlwe_q <= '0;
            poly_q <= '0;
            op_q <= '0;
            occ_q <= '0;
            cnt_q <= '0;
            pv_q <= '0;
            pl_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            lst_q <= '0;
        end else begin
            state_q <= state_d;
            pairs_q <= pairs_d;
            idx_q <= idx_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            rlwe_q <= rlwe_d;
            poly_q <= poly_d;
            op_q <= op_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            pv_q <= pv_d;
            pl_q <= pl_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            lst_q <= lst_d;
        end
    end
    // payload storage needs no reset: it is only visible while cnt_q is nonzero
    always_ff @(posedge clk) mem_q <= mem_d;
`ifdef FHE_DRAIN_STATS_EN
    logic [31:0] polys_q, polys_d, stalls_q, stalls_d;
    assign polys_d = polys_q + 32'(bus.rd_finish);
    assign stalls_d = stalls_q + 32'(bus.m_valid & ~bus.m_ready);
    always_ff @(posedge clk) begin
        polys_q <= rst ? '0 : polys_d;
        stalls_q <= rst ? '0 : stalls_d;
    end
    assign stat_polys = polys_q;
    assign stat_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_poly_fifo_drain.sv
// tb_poly_fifo_drain: directed bench for poly_fifo_drain with RD_LAT=1 and RD_LAT=2 instances
module tb_poly_fifo_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] s2a, s2b;

    poly_fifo_drain_if #(.ADDR_WIDTH(8), .BIT_WIDTH(8), .LINE_SIZE(8)) b1 ();
    poly_fifo_drain_if #(.ADDR_WIDTH(8), .BIT_WIDTH(8), .LINE_SIZE(8)) b2 ();

    poly_fifo_drain #(.ADDR_WIDTH(8), .BIT_WIDTH(8), .LINE_SIZE(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(b1));
    poly_fifo_drain #(.ADDR_WIDTH(8), .BIT_WIDTH(8), .LINE_SIZE(8), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2));

    always #5 clk = ~clk;

    function automatic logic [63:0] line_val(input logic [3:0] tag, input logic [7:0] k);
        return {4'h0, tag, 24'h5A5A5A, 24'h0, k};
    endfunction

    // FIFO memory models: buffer contents are tagged by the current poly_id
    always @(posedge clk) begin
        cyc <= cyc + 1;
        b1.dA <= line_val(b1.poly_id, b1.addrA);
        b1.dB <= line_val(b1.poly_id, b1.addrB);
        s2a <= line_val(b2.poly_id, b2.addrA);
        s2b <= line_val(b2.poly_id, b2.addrB);
        b2.dA <= s2a;
        b2.dB <= s2b;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pat 0: m_ready always high; pat 1: m_ready 1,0,0,1 repeating
    task automatic drain1(input int pairs, input int pat, input logic [3:0] tag, input int stop,
                          output int first_c, output int last_c);
        int acc;
        logic stall;
        logic [127:0] held;
        acc = 0;
        stall = 1'b0;
        held = '0;
        first_c = -1;
        last_c = -1;
        for (int i = 0; i < 1000 && acc < stop; i++) begin
            @(negedge clk);
            b1.m_ready = (pat == 0) || (i % 4 == 0) || (i % 4 == 3);
            if (stall) chk("stall_hold", b1.m_data, held);
            if (pat == 1) chk("occ_bound", 128'(int'(b1.addrA) - acc <= 2), 128'(1));
            chk("rd_finish_busy", b1.rd_finish, 0);
            if (first_c < 0 && b1.m_valid) first_c = cyc;
            if (b1.m_valid && b1.m_ready) begin
                chk("beat_data", b1.m_data, {line_val(tag, 8'(acc + pairs)), line_val(tag, 8'(acc))});
                chk("beat_last", b1.m_last, acc == pairs - 1);
                chk("beat_poly_id", b1.m_poly_id, tag);
                if (b1.m_last) last_c = cyc;
                acc++;
            end
            stall = b1.m_valid && !b1.m_ready;
            held = b1.m_data;
        end
        chk("drain_count", acc, stop);
    endtask

    initial begin
        int t0, fc, lc, fc2, lc2, n, k;
        b1.empty = 1'b1;
        b1.m_ready = 1'b0;
        b1.length = 12'd1024;
        b1.rlwe_id = 4'd3;
        b1.poly_id = 4'd0;
        b1.opcode = 4'd5;
        b2.empty = 1'b1;
        b2.m_ready = 1'b0;
        b2.length = 12'd1024;
        b2.rlwe_id = 4'd0;
        b2.poly_id = 4'd5;
        b2.opcode = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_addrA", b1.addrA, 0);
        chk("reset_addrB", b1.addrB, 0);
        chk("reset_rd_finish", b1.rd_finish, 0);
        chk("reset_m_valid", b1.m_valid, 0);
        chk("reset_m_last", b1.m_last, 0);
        chk("reset_m_data", b1.m_data, 0);
        chk("reset_hdr", {b1.m_rlwe_id, b1.m_poly_id, b1.m_opcode}, 0);
        chk("reset_dut2_valid", b2.m_valid, 0);

        // basic drain, 1024 coefficients -> 64 pairs
        b1.m_ready = 1'b1;
        t0 = cyc;
        b1.empty = 1'b0;
        drain1(64, 0, 4'd0, 64, fc, lc);
        b1.empty = 1'b1;
        chk("basic_first_beat", fc, t0 + 2);
        chk("basic_no_bubbles", lc - fc, 63);
        @(negedge clk);
        chk("basic_rd_finish", b1.rd_finish, 1);
        chk("basic_rlwe_id", b1.m_rlwe_id, 4'd3);
        chk("basic_opcode", b1.m_opcode, 4'd5);
        @(negedge clk);
        chk("basic_rd_finish_pulse", b1.rd_finish, 0);
        chk("basic_idle_valid", b1.m_valid, 0);
        repeat (3) @(negedge clk);

        // backpressure
        b1.poly_id = 4'd2;
        b1.empty = 1'b0;
        drain1(64, 1, 4'd2, 64, fc, lc);
        b1.empty = 1'b1;
        @(negedge clk);
        chk("bp_rd_finish", b1.rd_finish, 1);
        @(negedge clk);
        chk("bp_rd_finish_pulse", b1.rd_finish, 0);
        repeat (3) @(negedge clk);

        // back-to-back buffers
        b1.poly_id = 4'd0;
        b1.m_ready = 1'b1;
        b1.empty = 1'b0;
        drain1(64, 0, 4'd0, 64, fc, lc);
        b1.poly_id = 4'd1;
        @(negedge clk);
        chk("b2b_rd_finish", b1.rd_finish, 1);
        drain1(64, 0, 4'd1, 64, fc2, lc2);
        b1.empty = 1'b1;
        chk("b2b_restart_gap", fc2, lc + 5);
        @(negedge clk);
        chk("b2b_rd_finish2", b1.rd_finish, 1);
        repeat (4) @(negedge clk);

        // minimum length: one pair
        b1.length = 12'd16;
        b1.poly_id = 4'd6;
        t0 = cyc;
        b1.empty = 1'b0;
        drain1(1, 0, 4'd6, 1, fc, lc);
        b1.empty = 1'b1;
        chk("min_first_beat", fc, t0 + 2);
        chk("min_single_beat", lc, fc);
        @(negedge clk);
        chk("min_rd_finish", b1.rd_finish, 1);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(b1.rd_finish);
            n += int'(b1.m_valid);
        end
        chk("min_single_pulse", n, 0);

        // reset in the middle of a polynomial
        b1.length = 12'd1024;
        b1.poly_id = 4'd3;
        b1.empty = 1'b0;
        drain1(64, 0, 4'd3, 11, fc, lc);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", b1.m_valid, 0);
        chk("rst_mid_rd_finish", b1.rd_finish, 0);
        chk("rst_mid_addrA", b1.addrA, 0);
        chk("rst_mid_poly_id", b1.m_poly_id, 0);
        rst = 1'b0;
        b1.poly_id = 4'd4;
        t0 = cyc;
        drain1(64, 0, 4'd4, 64, fc, lc);
        b1.empty = 1'b1;
        chk("rst_fresh_first_beat", fc, t0 + 2);
        @(negedge clk);
        chk("rst_fresh_rd_finish", b1.rd_finish, 1);

        // RD_LAT=2: stall the consumer for 20 cycles
        b2.empty = 1'b0;
        repeat (20) @(negedge clk);
        b2.empty = 1'b1;
        chk("lat2_issued_pairs", b2.addrA, 3);
        chk("lat2_valid_held", b2.m_valid, 1);
        chk("lat2_head_data", b2.m_data, {line_val(4'd5, 8'd64), line_val(4'd5, 8'd0)});
        chk("lat2_head_last", b2.m_last, 0);
        b2.m_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 200 && k < 64; i++) begin
            if (b2.m_valid) begin
                chk("lat2_beat_data", b2.m_data, {line_val(4'd5, 8'(k + 64)), line_val(4'd5, 8'(k))});
                chk("lat2_beat_last", b2.m_last, k == 63);
                k++;
            end
            @(negedge clk);
        end
        chk("lat2_beat_count", k, 64);
        chk("lat2_rd_finish", b2.rd_finish, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
